// File: rtl/vga_pixel_fetch_if.sv
// Bundle between the sync/timing stages, the frame buffer and the pixel-fetch stage.
// The master side drives the timing flags and returns read data; the slave is the fetch stage.
interface vga_pixel_fetch_if #(
  parameter int unsigned ADDR_BIT = 19,
  parameter int unsigned RGB_BIT  = 12
);
  logic                i_px_clk;
  logic                i_hsync;
  logic                i_vsync;
  logic                i_haddr;
  logic                i_vaddr;
  logic                o_rd_en;
  logic [ADDR_BIT-1:0] o_rd_addr;
  logic [RGB_BIT-1:0]  i_rd_data;
  logic                o_hsync;
  logic                o_vsync;
  logic [RGB_BIT-1:0]  o_rgb;
  logic                o_overrun;

  modport master (
    output i_px_clk, i_hsync, i_vsync, i_haddr, i_vaddr, i_rd_data,
    input  o_rd_en, o_rd_addr, o_hsync, o_vsync, o_rgb, o_overrun
  );

  modport slave (
    input  i_px_clk, i_hsync, i_vsync, i_haddr, i_vaddr, i_rd_data,
    output o_rd_en, o_rd_addr, o_hsync, o_vsync, o_rgb, o_overrun
  );
endinterface

// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage: issues one frame-buffer read per visible pixel strobe, captures the
// returned word after RD_LATENCY clks and emits sync + RGB delayed by one strobe.
module vga_pixel_fetch #(
  parameter int unsigned H_PIXELS   = 640,
  parameter int unsigned V_LINES    = 480,
  parameter int unsigned ADDR_BIT   = 19,
  parameter int unsigned RGB_BIT    = 12,
  parameter int unsigned RD_LATENCY = 1
) (
  input logic              clk,
  input logic              i_sclr,
  vga_pixel_fetch_if.slave bus
);

  localparam logic [ADDR_BIT-1:0] LAST_ADDR = ADDR_BIT'(H_PIXELS * V_LINES - 1);

  logic                  visible;
  logic                  rd_en;
  logic                  strobe;
  logic [ADDR_BIT-1:0]   addr_q, addr_d;
  logic                  sat_q, sat_d;
  logic                  ovr_q, ovr_d;
  logic [RD_LATENCY-1:0] rd_pipe_q;
  logic [RGB_BIT-1:0]    cap_q;
  logic                  hs_dly_q, vs_dly_q, vis_dly_q;
  logic                  hsync_q, vsync_q;
  logic [RGB_BIT-1:0]    rgb_q;

  assign strobe  = bus.i_px_clk & ~i_sclr;
  assign visible = bus.i_haddr & bus.i_vaddr;
  assign rd_en   = strobe & visible;

  // sat_q marks that a read has already been issued at the last frame address.
  always_comb begin
    addr_d = addr_q;
    sat_d  = sat_q;
    ovr_d  = ovr_q;
    if (strobe && !bus.i_vaddr) begin
      addr_d = '0;
      sat_d  = 1'b0;
    end else if (rd_en) begin
      if (sat_q) begin
        ovr_d = 1'b1;
      end
      if (addr_q == LAST_ADDR) begin
        sat_d = 1'b1;
      end else begin
        addr_d = addr_q + ADDR_BIT'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      addr_q    <= '0;
      sat_q     <= 1'b0;
      ovr_q     <= 1'b0;
      rd_pipe_q <= '0;
      cap_q     <= '0;
      hs_dly_q  <= 1'b0;
      vs_dly_q  <= 1'b0;
      vis_dly_q <= 1'b0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      rgb_q     <= '0;
    end else begin
      addr_q    <= addr_d;
      sat_q     <= sat_d;
      ovr_q     <= ovr_d;
      rd_pipe_q <= RD_LATENCY'({rd_pipe_q, rd_en});
      if (rd_pipe_q[RD_LATENCY-1]) begin
        cap_q <= bus.i_rd_data;
      end
      // Two-stage sync path keeps sync aligned with RGB, which lags its strobe by one.
      if (strobe) begin
        hs_dly_q  <= bus.i_hsync;
        vs_dly_q  <= bus.i_vsync;
        vis_dly_q <= visible;
        hsync_q   <= hs_dly_q;
        vsync_q   <= vs_dly_q;
        rgb_q     <= vis_dly_q ? cap_q : '0;
      end
    end
  end

  assign bus.o_rd_en   = rd_en;
  assign bus.o_rd_addr = addr_q;
  assign bus.o_hsync   = hsync_q;
  assign bus.o_vsync   = vsync_q;
  assign bus.o_rgb     = rgb_q;
  assign bus.o_overrun = ovr_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench: three fetch stages (read latency 1, 2, 3) share one stimulus stream
// on a reduced 8x4 visible / 12x7 total raster and are checked against one expectation queue.
module tb_vga_pixel_fetch;

  localparam int unsigned H_PIXELS = 8;
  localparam int unsigned V_LINES  = 4;
  localparam int unsigned H_TOTAL  = 12;
  localparam int unsigned V_TOTAL  = 7;
  localparam int unsigned ADDR_BIT = 5;
  localparam int unsigned RGB_BIT  = 12;
  localparam int unsigned NPIX     = H_PIXELS * V_LINES;
  localparam logic [ADDR_BIT-1:0] LAST = ADDR_BIT'(NPIX - 1);

  typedef struct packed {
    logic               hs;
    logic               vs;
    logic [RGB_BIT-1:0] rgb;
    logic               ovr;
  } pix_t;

  logic clk = 1'b0;
  logic sclr = 1'b1;
  logic px = 1'b0, hs = 1'b0, vs = 1'b0, ha = 1'b0, va = 1'b0;
  logic done = 1'b0;

  always #5 clk = ~clk;

  vga_pixel_fetch_if #(.ADDR_BIT(ADDR_BIT), .RGB_BIT(RGB_BIT)) bus0 ();
  vga_pixel_fetch_if #(.ADDR_BIT(ADDR_BIT), .RGB_BIT(RGB_BIT)) bus1 ();
  vga_pixel_fetch_if #(.ADDR_BIT(ADDR_BIT), .RGB_BIT(RGB_BIT)) bus2 ();

  vga_pixel_fetch #(.H_PIXELS(H_PIXELS), .V_LINES(V_LINES), .ADDR_BIT(ADDR_BIT),
    .RGB_BIT(RGB_BIT), .RD_LATENCY(1)) dut0 (.clk(clk), .i_sclr(sclr), .bus(bus0));
  vga_pixel_fetch #(.H_PIXELS(H_PIXELS), .V_LINES(V_LINES), .ADDR_BIT(ADDR_BIT),
    .RGB_BIT(RGB_BIT), .RD_LATENCY(2)) dut1 (.clk(clk), .i_sclr(sclr), .bus(bus1));
  vga_pixel_fetch #(.H_PIXELS(H_PIXELS), .V_LINES(V_LINES), .ADDR_BIT(ADDR_BIT),
    .RGB_BIT(RGB_BIT), .RD_LATENCY(3)) dut2 (.clk(clk), .i_sclr(sclr), .bus(bus2));

  function automatic logic [RGB_BIT-1:0] ram_f(input logic [ADDR_BIT-1:0] a);
    return RGB_BIT'(12'hABC + 12'(a) * 12'd37);
  endfunction

  assign bus0.i_px_clk = px; assign bus1.i_px_clk = px; assign bus2.i_px_clk = px;
  assign bus0.i_hsync  = hs; assign bus1.i_hsync  = hs; assign bus2.i_hsync  = hs;
  assign bus0.i_vsync  = vs; assign bus1.i_vsync  = vs; assign bus2.i_vsync  = vs;
  assign bus0.i_haddr  = ha; assign bus1.i_haddr  = ha; assign bus2.i_haddr  = ha;
  assign bus0.i_vaddr  = va; assign bus1.i_vaddr  = va; assign bus2.i_vaddr  = va;

  // Frame-buffer models with 1, 2 and 3 clks of read latency.
  logic [ADDR_BIT-1:0] r0, r1a, r1b, r2a, r2b, r2c;
  always @(posedge clk) begin
    r0  <= bus0.o_rd_addr;
    r1a <= bus1.o_rd_addr; r1b <= r1a;
    r2a <= bus2.o_rd_addr; r2b <= r2a; r2c <= r2b;
  end
  assign bus0.i_rd_data = ram_f(r0);
  assign bus1.i_rd_data = ram_f(r1b);
  assign bus2.i_rd_data = ram_f(r2c);

  pix_t                out_a[3];
  logic                rd_a[3];
  logic [ADDR_BIT-1:0] ad_a[3];
  assign out_a[0] = {bus0.o_hsync, bus0.o_vsync, bus0.o_rgb, bus0.o_overrun};
  assign out_a[1] = {bus1.o_hsync, bus1.o_vsync, bus1.o_rgb, bus1.o_overrun};
  assign out_a[2] = {bus2.o_hsync, bus2.o_vsync, bus2.o_rgb, bus2.o_overrun};
  assign rd_a[0] = bus0.o_rd_en; assign rd_a[1] = bus1.o_rd_en; assign rd_a[2] = bus2.o_rd_en;
  assign ad_a[0] = bus0.o_rd_addr; assign ad_a[1] = bus1.o_rd_addr;
  assign ad_a[2] = bus2.o_rd_addr;

  pix_t                exp_q[$];
  logic [ADDR_BIT-1:0] addr_exp_q[$];

  // ---------------- stimulus + reference model ----------------
  logic [ADDR_BIT-1:0] m_addr = '0, p_addr = '0;
  logic m_sat = 1'b0, m_ovr = 1'b0, p_hs = 1'b0, p_vs = 1'b0, p_vis = 1'b0;

  task automatic model_reset();
    m_addr = '0; m_sat = 1'b0; m_ovr = 1'b0;
    p_hs = 1'b0; p_vs = 1'b0; p_vis = 1'b0; p_addr = '0;
  endtask

  task automatic do_strobe(input logic s_hs, input logic s_vs, input logic s_ha,
                           input logic s_va, input int idle);
    pix_t e;
    logic vis;
    logic [ADDR_BIT-1:0] cur;
    vis = s_ha & s_va;
    cur = m_addr;
    if (vis) begin
      addr_exp_q.push_back(m_addr);
      if (m_sat) m_ovr = 1'b1;
      if (m_addr == LAST) m_sat = 1'b1;
      else m_addr = m_addr + ADDR_BIT'(1);
    end
    if (!s_va) begin
      m_addr = '0;
      m_sat  = 1'b0;
    end
    e.hs  = p_hs;
    e.vs  = p_vs;
    e.rgb = p_vis ? ram_f(p_addr) : '0;
    e.ovr = m_ovr;
    exp_q.push_back(e);
    p_hs = s_hs; p_vs = s_vs; p_vis = vis;
    if (vis) p_addr = cur;
    @(posedge clk); #1;
    px = 1'b1; hs = s_hs; vs = s_vs; ha = s_ha; va = s_va;
    @(posedge clk); #1;
    px = 1'b0;
    repeat (idle) @(posedge clk);
  endtask

  task automatic run_frame(input int max_strobes);
    int n;
    n = 0;
    for (int v = 0; v < int'(V_TOTAL); v++) begin
      for (int h = 0; h < int'(H_TOTAL); h++) begin
        if (n == max_strobes) return;
        do_strobe((h == H_PIXELS + 1) || (h == H_PIXELS + 2), v == V_LINES + 1,
                  h < int'(H_PIXELS), v < int'(V_LINES), 2 + (h % 3));
        n++;
      end
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    sclr = 1'b1;
    @(posedge clk); #1;
    sclr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 sclr = 1'b0;
    model_reset();
    run_frame(20);                       // partial frame, then reset mid-frame
    reset_pulse();
    run_frame(H_TOTAL * V_TOTAL);        // two full frames
    run_frame(H_TOTAL * V_TOTAL);
    repeat (NPIX + 2) do_strobe(1'b0, 1'b0, 1'b1, 1'b1, 2);   // overrun
    do_strobe(1'b0, 1'b1, 1'b0, 1'b0, 3);                     // frame restart
    repeat (3) do_strobe(1'b1, 1'b0, 1'b1, 1'b1, 2 + 3);      // wider idle gaps
    reset_pulse();
    run_frame(30);
    repeat (5) @(posedge clk);
    done = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  // ---------------- monitor / scoreboard ----------------
  int   checks = 0, errors = 0;
  pix_t last = '0;
  logic sclr_prev = 1'b0, strobe_prev = 1'b0;

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d: got %h, required %h (t=%0t)", name, d, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    pix_t e;
    logic [ADDR_BIT-1:0] ea;
    if (done) begin
      check("exp_q_drained", 0, 32'(exp_q.size()), 32'd0);
      check("addr_q_drained", 0, 32'(addr_exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
    if (sclr_prev) begin
      last = '0;
      for (int d = 0; d < 3; d++) begin
        check("reset_out", d, 32'(out_a[d]), 32'd0);
        check("reset_addr", d, 32'(ad_a[d]), 32'd0);
        check("reset_rd_en", d, 32'(rd_a[d]), 32'd0);
      end
    end else if (strobe_prev) begin
      if (exp_q.size() == 0) begin
        check("pix_unexpected", 0, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        last = e;
        for (int d = 0; d < 3; d++) check("pix_out", d, 32'(out_a[d]), 32'(e));
      end
    end else begin
      for (int d = 0; d < 3; d++) check("hold_out", d, 32'(out_a[d]), 32'(last));
    end
    if (rd_a[0] || rd_a[1] || rd_a[2]) begin
      if (addr_exp_q.size() == 0) begin
        check("rd_unexpected", 0, 32'd1, 32'd0);
      end else begin
        ea = addr_exp_q.pop_front();
        for (int d = 0; d < 3; d++) begin
          check("rd_en", d, 32'(rd_a[d]), 32'd1);
          check("rd_addr", d, 32'(ad_a[d]), 32'(ea));
        end
      end
    end
    sclr_prev   = sclr;
    strobe_prev = px & ~sclr;
  end

endmodule
